oversampled_tx: RTL

OVERSAMPLED_TX -- requirements
Module: oversampled_tx

---
 rtl/oversampled_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/oversampled_tx.sv
// rtl/oversampled_tx.sv - oversampled serial transmitter: start bit, DATA_W bits LSB first, stop bit.
// Every symbol is held for OSF clock cycles, and all outputs are registered.
module oversampled_tx #(
  parameter int DATA_W = 8,
  parameter int OSF    = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Valid,
  output logic              Ready,
  output logic              TxOut,
  output logic              Busy
);

  localparam int SW = (OSF > 1) ? $clog2(OSF) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(OSF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [SW-1:0]     sym_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic              sym_end;

  assign shifted = shreg >> 1;
  // With OSF=1 the counter stays at 0, so every cycle is a symbol boundary.
  assign sym_end = (sym_cnt == SYM_LAST);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      sym_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      TxOut   <= 1'b1;
      Ready   <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Valid) begin
            shreg   <= DataIn;
            state   <= START;
            sym_cnt <= '0;
            bit_cnt <= '0;
            TxOut   <= 1'b0;
            Ready   <= 1'b0;
            Busy    <= 1'b1;
          end
        end
        START: begin
          if (sym_end) begin
            sym_cnt <= '0;
            state   <= DATA;
            TxOut   <= shreg[0];
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
        DATA: begin
          if (sym_end) begin
            sym_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
              TxOut <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shifted;
              TxOut   <= shifted[0];
            end
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
        STOP: begin
          if (sym_end) begin
            sym_cnt <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
            Ready   <= 1'b1;
            Busy    <= 1'b0;
          end else begin
            sym_cnt <= sym_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          TxOut <= 1'b1;
          Ready <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
